// File: rtl/ip_gpio_x_if.sv
// Bus bundle for ip_gpio_x: the MSX-50BUS I/O-space signals between the
// host side (master) and the GPIO block (slave).
interface ip_gpio_x_if;
    logic [15:0] address;
    logic        read_ready;
    logic [7:0]  read_data;
    logic [7:0]  write_data;
    logic        io_read;
    logic        io_write;

    modport master (
        output address,
        output write_data,
        output io_read,
        output io_write,
        input  read_ready,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  io_read,
        input  io_write,
        output read_ready,
        output read_data
    );
endinterface

// File: rtl/ip_gpio_x.sv
// ip_gpio_x: multi-port bidirectional GPIO on the MSX-50BUS I/O space.
// Each 8-bit port has an output latch, a direction register and an input
// synchronizer. Building with IP_GPIO_X_IRQ_EN defined adds per-bit
// rising-edge interrupt enable/status registers and the int_n line.
// Register map per port p at io_address + 4*p:
//   +0 DATA, +1 DIR, +2 IEN, +3 ISTAT (write-1-to-clear)
module ip_gpio_x #(
    parameter logic [7:0] io_address  = 8'h10,
    parameter int         PORTS       = 2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    ip_gpio_x_if.slave         bus,
    output logic [8*PORTS-1:0] gpo,
    output logic [8*PORTS-1:0] gpo_oe,
    input  logic [8*PORTS-1:0] gpi,
    output logic               int_n
);
    localparam int WIDTH = 8 * PORTS;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DIR  = 2'd1;
`ifdef IP_GPIO_X_IRQ_EN
    localparam logic [1:0] REG_IEN   = 2'd2;
    localparam logic [1:0] REG_ISTAT = 2'd3;
`endif

    // Address decode
    logic [7:0] addr_lo;
    logic [8:0] addr_offset;
    logic       hit;
    logic [1:0] port_sel;
    logic [1:0] reg_sel;
    logic       wr_hit;
    logic       rd_hit;

    // Pin-side state
    logic [WIDTH-1:0]                  out_latch;
    logic [WIDTH-1:0]                  dir_reg;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
    logic [WIDTH-1:0]                  sync_in;

    // Read response pipe
    logic [7:0] rd_value;
    logic       rd_ready_q;
    logic [7:0] rd_data_q;

`ifdef IP_GPIO_X_IRQ_EN
    logic [WIDTH-1:0] ien_reg;
    logic [WIDTH-1:0] istat_reg;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clear_mask;
    logic             int_n_q;
`endif

    // Only the low address byte is decoded; the offset is computed in 9 bits
    // so an address below the base wraps far outside the window instead of
    // aliasing into it, and a window ending at 8'hFF does not overflow.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.address[15:8], addr_offset[8:4]};

    assign addr_lo     = bus.address[7:0];
    assign addr_offset = {1'b0, addr_lo} - {1'b0, io_address};
    assign hit         = (addr_offset < 9'(4 * PORTS));
    assign port_sel    = addr_offset[3:2];
    assign reg_sel     = addr_lo[1:0];
    assign wr_hit      = hit && bus.io_write;
    assign rd_hit      = hit && bus.io_read;

    // Output latch and direction register take bus writes to the selected port
    always_ff @(posedge clk) begin
        if (reset) begin
            out_latch <= '0;
            dir_reg   <= '0;
        end else if (wr_hit) begin
            for (int p = 0; p < PORTS; p++) begin
                if (port_sel == 2'(p)) begin
                    if (reg_sel == REG_DATA) begin
                        out_latch[8*p +: 8] <= bus.write_data;
                    end
                    if (reg_sel == REG_DIR) begin
                        dir_reg[8*p +: 8] <= bus.write_data;
                    end
                end
            end
        end
    end

    // Pin input synchronizer chain; the last stage is the usable input value
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain[0] <= gpi;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
        end
    end

    assign sync_in = sync_chain[SYNC_STAGES-1];

    // Read mux: DATA shows the latch on output bits and the pin on input bits
    always_comb begin
        rd_value = 8'h00;
        for (int p = 0; p < PORTS; p++) begin
            if (port_sel == 2'(p)) begin
                case (reg_sel)
                    REG_DATA: rd_value = (dir_reg[8*p +: 8] & out_latch[8*p +: 8]) |
                                         (~dir_reg[8*p +: 8] & sync_in[8*p +: 8]);
                    REG_DIR:  rd_value = dir_reg[8*p +: 8];
`ifdef IP_GPIO_X_IRQ_EN
                    REG_IEN:   rd_value = ien_reg[8*p +: 8];
                    REG_ISTAT: rd_value = istat_reg[8*p +: 8];
`endif
                    default:  rd_value = 8'h00;
                endcase
            end
        end
    end

    // Read response: captured from pre-write state, valid for exactly one cycle per strobe cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ready_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            rd_ready_q <= rd_hit;
            rd_data_q  <= rd_hit ? rd_value : 8'h00;
        end
    end

    assign bus.read_ready = rd_ready_q;
    assign bus.read_data  = rd_data_q;
    assign gpo            = out_latch;
    assign gpo_oe         = dir_reg;

`ifdef IP_GPIO_X_IRQ_EN
    // Output bits and disabled bits never raise status
    assign rise = sync_in & ~prev_in & ~dir_reg & ien_reg;

    // One-cycle history of the synchronized inputs for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_in <= '0;
        end else begin
            prev_in <= sync_in;
        end
    end

    // Write-1-to-clear mask aimed at the addressed port's status byte
    always_comb begin
        clear_mask = '0;
        if (wr_hit && (reg_sel == REG_ISTAT)) begin
            for (int p = 0; p < PORTS; p++) begin
                if (port_sel == 2'(p)) begin
                    clear_mask[8*p +: 8] = bus.write_data;
                end
            end
        end
    end

    // Interrupt enable register takes bus writes to the selected port
    always_ff @(posedge clk) begin
        if (reset) begin
            ien_reg <= '0;
        end else if (wr_hit && (reg_sel == REG_IEN)) begin
            for (int p = 0; p < PORTS; p++) begin
                if (port_sel == 2'(p)) begin
                    ien_reg[8*p +: 8] <= bus.write_data;
                end
            end
        end
    end

    // Status: clear first, then set, so a coincident edge is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            istat_reg <= '0;
        end else begin
            istat_reg <= (istat_reg & ~clear_mask) | rise;
        end
    end

    // Registered interrupt line, one cycle behind the status bits
    always_ff @(posedge clk) begin
        if (reset) begin
            int_n_q <= 1'b1;
        end else begin
            int_n_q <= ~(|istat_reg);
        end
    end

    assign int_n = int_n_q;
`else
    assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_ip_gpio_x.sv
// Self-checking bench for ip_gpio_x (PORTS=2, base 8'h10, SYNC_STAGES=2).
// Directed scenarios followed by randomized bus/pin traffic, all compared
// against a behavioural register-map model held in this module.
// Follows IP_GPIO_X_IRQ_EN the same way the design does.
module tb_ip_gpio_x;
    localparam int         NPORTS = 2;
    localparam int         SYNC   = 2;
    localparam logic [7:0] BASE   = 8'h10;
`ifdef IP_GPIO_X_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic [8*NPORTS-1:0] gpo;
    logic [8*NPORTS-1:0] gpo_oe;
    logic [8*NPORTS-1:0] gpi;
    logic                int_n;

    ip_gpio_x_if bus ();

    ip_gpio_x #(
        .io_address  (BASE),
        .PORTS       (NPORTS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .gpo    (gpo),
        .gpo_oe (gpo_oe),
        .gpi    (gpi),
        .int_n  (int_n)
    );

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference model: register map per port plus a pin-delay history
    logic [7:0]  m_out   [NPORTS];
    logic [7:0]  m_dir   [NPORTS];
    logic [7:0]  m_ien   [NPORTS];
    logic [7:0]  m_istat [NPORTS];
    logic [15:0] m_hist  [$];
    logic        m_ready;
    logic [7:0]  m_rdata;
    logic        m_int_n;
    logic [15:0] pins;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus never completes
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got no_finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before it
    task automatic modelStep(input logic rst, input logic [15:0] addr, input logic rd,
                             input logic wr, input logic [7:0] wd, input logic [15:0] pin_val);
        logic [15:0] sync_now;
        logic [15:0] prev_now;
        logic [7:0]  readback;
        logic [7:0]  rise [NPORTS];
        logic        any_stat;
        int          rel;
        int          p;
        int          off;
        bit          hit;

        if (rst) begin
            for (int q = 0; q < NPORTS; q++) begin
                m_out[q] = 8'h00; m_dir[q] = 8'h00; m_ien[q] = 8'h00; m_istat[q] = 8'h00;
            end
            m_hist = {};
            for (int k = 0; k <= SYNC; k++) m_hist.push_back(16'h0000);
            m_ready = 1'b0;
            m_rdata = 8'h00;
            m_int_n = 1'b1;
            return;
        end

        // The pin seen SYNC edges ago is the synchronized input; one more is its history
        sync_now = m_hist[SYNC-1];
        prev_now = m_hist[SYNC];

        rel = int'(addr[7:0]) - int'(BASE);
        hit = (rel >= 0) && (rel < 4 * NPORTS);
        p   = hit ? rel / 4 : 0;
        off = int'(addr[1:0]);

        readback = 8'h00;
        if (hit) begin
            case (off)
                0: for (int i = 0; i < 8; i++)
                       readback[i] = m_dir[p][i] ? m_out[p][i] : sync_now[8*p + i];
                1: readback = m_dir[p];
                2: readback = IRQ ? m_ien[p] : 8'h00;
                default: readback = IRQ ? m_istat[p] : 8'h00;
            endcase
        end
        m_ready = hit && rd;
        m_rdata = m_ready ? readback : 8'h00;

        any_stat = 1'b0;
        for (int q = 0; q < NPORTS; q++) any_stat = any_stat | (m_istat[q] != 8'h00);
        m_int_n = IRQ ? !any_stat : 1'b1;

        for (int q = 0; q < NPORTS; q++) begin
            rise[q] = 8'h00;
            for (int i = 0; i < 8; i++)
                rise[q][i] = IRQ && sync_now[8*q + i] && !prev_now[8*q + i] && !m_dir[q][i] && m_ien[q][i];
        end

        if (hit && wr) begin
            case (off)
                0: m_out[p] = wd;
                1: m_dir[p] = wd;
                2: if (IRQ) m_ien[p] = wd;
                default: if (IRQ) m_istat[p] = m_istat[p] & ~wd;
            endcase
        end
        for (int q = 0; q < NPORTS; q++) m_istat[q] = m_istat[q] | rise[q];

        m_hist.push_front(pin_val);
        void'(m_hist.pop_back());
    endtask

    // Drive one cycle of bus/pin inputs, clock it, then compare every output
    task automatic applyStimulus(input logic rst, input logic [15:0] addr, input logic rd,
                                 input logic wr, input logic [7:0] wd, input logic [15:0] pin_val);
        logic [15:0] exp_gpo;
        logic [15:0] exp_oe;
        reset          = rst;
        bus.address    = addr;
        bus.io_read    = rd;
        bus.io_write   = wr;
        bus.write_data = wd;
        gpi            = pin_val;
        modelStep(rst, addr, rd, wr, wd, pin_val);
        @(posedge clk);
        #1;
        for (int q = 0; q < NPORTS; q++) begin
            exp_gpo[8*q +: 8] = m_out[q];
            exp_oe[8*q +: 8]  = m_dir[q];
        end
        checkOutput("read_ready", bus.read_ready, m_ready);
        checkOutput("read_data", bus.read_data, m_rdata);
        checkOutput("gpo", gpo, exp_gpo);
        checkOutput("gpo_oe", gpo_oe, exp_oe);
        checkOutput("int_n", int_n, m_int_n);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, pins);
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(1'b0, {8'h00, a}, 1'b0, 1'b1, d, pins);
    endtask

    task automatic busRead(input logic [7:0] a);
        applyStimulus(1'b0, {8'h00, a}, 1'b1, 1'b0, 8'h00, pins);
    endtask

    // Directed scenarios, then randomized traffic, then the summary
    initial begin
        logic [15:0] r_addr;
        logic [7:0]  r_lo;

        pins = 16'h00A5;
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, pins);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, pins);
        checkOutput("rst_gpo", gpo, 16'h0000);
        checkOutput("rst_gpo_oe", gpo_oe, 16'h0000);
        checkOutput("rst_int_n", int_n, 1'b1);
        checkOutput("rst_ready", bus.read_ready, 1'b0);
        checkOutput("rst_data", bus.read_data, 8'h00);

        idle(3);
        busRead(8'h10);
        checkOutput("p0_pin_ready", bus.read_ready, 1'b1);
        checkOutput("p0_pin_data", bus.read_data, 8'hA5);

        pins = 16'hF0A5;
        busWrite(8'h14, 8'h3C);
        busWrite(8'h15, 8'h0F);
        idle(3);
        checkOutput("p1_gpo", gpo[15:8], 8'h3C);
        checkOutput("p1_gpo_oe", gpo_oe[15:8], 8'h0F);
        busRead(8'h14);
        checkOutput("p1_mixed_data", bus.read_data, 8'hFC);

        // Read and write together return the old value
        applyStimulus(1'b0, 16'h0015, 1'b1, 1'b1, 8'h81, pins);
        checkOutput("rw_old_value", bus.read_data, 8'h0F);
        busRead(8'h15);
        checkOutput("rw_new_value", bus.read_data, 8'h81);

`ifdef IP_GPIO_X_IRQ_EN
        pins = 16'hF0A4;
        idle(4);
        busWrite(8'h12, 8'h01);
        pins = 16'hF0A5;
        idle(SYNC + 1);
        checkOutput("irq_int_n_lag", int_n, 1'b1);
        busRead(8'h13);
        checkOutput("irq_istat_set", bus.read_data, 8'h01);
        checkOutput("irq_int_n_low", int_n, 1'b0);
        busWrite(8'h13, 8'h01);
        idle(1);
        checkOutput("irq_w1c_int_n", int_n, 1'b1);
        busRead(8'h13);
        checkOutput("irq_w1c_istat", bus.read_data, 8'h00);

        pins = 16'hF0A4;
        idle(SYNC + 2);
        pins = 16'hF0A5;
        idle(SYNC + 1);
        pins = 16'hF0A4;
        idle(SYNC + 2);
        pins = 16'hF0A5;
        idle(1);
        idle(SYNC - 1);
        busWrite(8'h13, 8'h01);
        busRead(8'h13);
        checkOutput("irq_set_wins", bus.read_data, 8'h01);
        checkOutput("irq_set_wins_int_n", int_n, 1'b0);
        busWrite(8'h13, 8'hFF);
        idle(2);
`else
        busWrite(8'h12, 8'hFF);
        busWrite(8'h13, 8'hFF);
        busRead(8'h13);
        checkOutput("noirq_istat", bus.read_data, 8'h00);
        checkOutput("noirq_istat_ready", bus.read_ready, 1'b1);
        busRead(8'h12);
        checkOutput("noirq_ien", bus.read_data, 8'h00);
        checkOutput("noirq_int_n", int_n, 1'b1);
`endif

        busRead(8'h18);
        checkOutput("outside_no_ready", bus.read_ready, 1'b0);
        busWrite(8'h11, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            busRead(8'h11);
            checkOutput("held_read_ready", bus.read_ready, 1'b1);
            checkOutput("held_read_data", bus.read_data, 8'h5A);
        end
        idle(1);
        checkOutput("held_read_end", bus.read_ready, 1'b0);

        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 8'h00, pins);
        checkOutput("abort_ready", bus.read_ready, 1'b0);
        checkOutput("abort_gpo", gpo, 16'h0000);
        checkOutput("abort_gpo_oe", gpo_oe, 16'h0000);
        idle(2);

        for (int n = 0; n < 2000; n++) begin
            r_lo   = ($urandom_range(0, 9) < 7) ? 8'(8'h10 + $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            r_addr = {8'($urandom_range(0, 255)), r_lo};
            if ($urandom_range(0, 4) == 0) pins = 16'($urandom);
            applyStimulus($urandom_range(0, 99) == 0, r_addr, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0), 8'($urandom), pins);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
